// File: rtl/lut_loader_pkg.sv
// rtl/lut_loader_pkg.sv - shared encoder LUT constants and loader state encoding
package lut_loader_pkg;

   localparam int LUT_DATA_WIDTH = 16;
   localparam int LUT_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      LDR_IDLE = 2'd0,
      LDR_LOAD = 2'd1,
      LDR_DONE = 2'd2
   } ldr_state_t;

endpackage

// File: rtl/lut_loader.sv
// rtl/lut_loader.sv - run-time loader for the entropy-encoder LUT with checksum verification
module lut_loader
   import lut_loader_pkg::*;
#(
   parameter int DATA_WIDTH = LUT_DATA_WIDTH,
   parameter int ADDR_WIDTH = LUT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] exp_checksum,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  lut_ready,
   output logic                  chk_err,
   output logic                  overrun,
   output logic [DATA_WIDTH-1:0] checksum
);

   ldr_state_t            state;
   ldr_state_t            state_next;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  hs;
   logic                  last_hs;
   logic                  enter_load;
   logic [DATA_WIDTH-1:0] sum_next;
   logic                  fin_q;
   logic                  match_q;

   assign s_ready    = (state == LDR_LOAD) && !abort;
   assign busy       = (state == LDR_LOAD);
   assign hs         = s_valid && s_ready;
   assign last_hs    = hs && (cnt == '1);
   assign enter_load = start && !abort && (state != LDR_LOAD);
   assign sum_next   = checksum + s_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LDR_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         LDR_IDLE: begin
            if (enter_load) state_next = LDR_LOAD;
         end
         LDR_LOAD: begin
            if (abort)        state_next = LDR_IDLE;
            else if (last_hs) state_next = LDR_DONE;
         end
         LDR_DONE: begin
            if (abort)           state_next = LDR_IDLE;
            else if (enter_load) state_next = LDR_LOAD;
         end
         default: state_next = LDR_IDLE;
      endcase
   end

   // Write port: one registered cycle behind the handshake that produced it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= hs;
         if (hs) begin
            wr_addr <= cnt;
            wr_data <= s_data;
         end
      end
   end

   // The final compare is registered into match_q, then published one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         checksum  <= '0;
         lut_ready <= 1'b0;
         chk_err   <= 1'b0;
         fin_q     <= 1'b0;
         match_q   <= 1'b0;
      end else begin
         fin_q <= last_hs;
         if (last_hs) begin
            match_q <= (sum_next == exp_checksum);
         end
         if (abort) begin
            cnt       <= '0;
            lut_ready <= 1'b0;
            chk_err   <= 1'b0;
         end else if (enter_load) begin
            cnt       <= '0;
            checksum  <= '0;
            lut_ready <= 1'b0;
            chk_err   <= 1'b0;
         end else begin
            if (fin_q) begin
               lut_ready <= match_q;
               chk_err   <= !match_q;
            end
            if (hs) begin
               cnt      <= cnt + 1'b1;
               checksum <= sum_next;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (enter_load) begin
         overrun <= 1'b0;
      end else if (s_valid && (state == LDR_DONE)) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lut_loader.sv
// tb/tb_lut_loader.sv - randomized self-checking bench for lut_loader against a cycle reference model
module tb_lut_loader;

   localparam int DW = 16;
   localparam int AW = 2;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic [DW-1:0] exp_checksum = '0;
   logic          s_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          lut_ready;
   logic          chk_err;
   logic          overrun;
   logic [DW-1:0] checksum;

   lut_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .exp_checksum(exp_checksum), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .lut_ready(lut_ready),
      .chk_err(chk_err), .overrun(overrun), .checksum(checksum)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: 0 idle, 1 loading, 2 done; words accepted counted in m_cnt.
   int          m_state = 0;
   int          m_cnt = 0;
   int          m_sum = 0;
   bit          m_rdy = 0, m_err = 0, m_ovr = 0, m_pend = 0, m_match = 0, m_wr = 0;
   int          m_wa = 0, m_wd = 0;
   logic [15:0] wbuf [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_sum = 0;
      m_rdy = 0; m_err = 0; m_ovr = 0; m_pend = 0; m_match = 0; m_wr = 0;
   endtask

   task automatic check_regs(input string ph);
      check({ph, ":busy"}, busy, m_state == 1);
      check({ph, ":wr_en"}, wr_en, m_wr);
      if (m_wr) begin
         check({ph, ":wr_addr"}, wr_addr, m_wa);
         check({ph, ":wr_data"}, wr_data, m_wd);
      end
      check({ph, ":lut_ready"}, lut_ready, m_rdy);
      check({ph, ":chk_err"}, chk_err, m_err);
      check({ph, ":overrun"}, overrun, m_ovr);
      check({ph, ":checksum"}, checksum, m_sum);
   endtask

   // Entered and left at posedge+1: drive, check s_ready at negedge, advance model, check registers.
   task automatic step(input bit v, input logic [15:0] d, input bit st, input bit ab,
                       input logic [15:0] ex);
      bit sr, hs, enter, pend_old, match_old;
      s_valid = v; s_data = d; start = st; abort = ab; exp_checksum = ex;
      @(negedge clk);
      sr = (m_state == 1) && !ab;
      check("s_ready", s_ready, sr);
      hs = v && sr;
      enter = st && !ab && (m_state != 1);
      @(posedge clk);
      #1;
      m_wr = hs;
      if (hs) begin m_wa = m_cnt; m_wd = d; end
      pend_old = m_pend; match_old = m_match; m_pend = 0;
      if (v && m_state == 2) m_ovr = 1;
      if (ab) begin
         m_state = 0; m_cnt = 0; m_rdy = 0; m_err = 0;
      end else if (enter) begin
         m_state = 1; m_cnt = 0; m_sum = 0; m_rdy = 0; m_err = 0; m_ovr = 0;
      end else begin
         if (pend_old) begin m_rdy = match_old; m_err = !match_old; end
         if (hs) begin
            m_sum = (m_sum + d) % 65536;
            if (m_cnt == N - 1) begin
               m_state = 2; m_pend = 1; m_match = (m_sum == ex);
            end
            m_cnt = (m_cnt + 1) % N;
         end
      end
      check_regs("cyc");
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, 16'h0);
   endtask

   task automatic run_load(input logic [15:0] ex, input int gap);
      step(0, 16'h0, 1, 0, ex);
      for (int i = 0; i < N; i++) begin
         step(1, wbuf[i], 0, 0, ex);
         if (i == 1) for (int g = 0; g < gap; g++) step(0, 16'hDEAD, 0, 0, ex);
      end
      idle_steps(2);
   endtask

   initial begin
      model_reset();
      #12;
      check("rst:s_ready", s_ready, 0);
      check_regs("rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      wbuf = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      run_load(16'h000A, 0);
      check("t1:lut_ready", lut_ready, 1);
      run_load(16'h000A, 3);
      check("t2:lut_ready", lut_ready, 1);

      wbuf = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000};
      run_load(16'h0001, 0);
      check("t3:checksum", checksum, 16'h0001);
      check("t3:lut_ready", lut_ready, 1);
      run_load(16'h0002, 0);
      check("t3b:chk_err", chk_err, 1);
      check("t3b:lut_ready", lut_ready, 0);

      wbuf = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      step(0, 16'h0, 1, 0, 16'h0);
      step(1, 16'h0011, 0, 0, 16'h0);
      step(1, 16'h0022, 0, 0, 16'h0);
      step(1, 16'h0033, 0, 1, 16'h0);
      step(1, 16'h0044, 0, 0, 16'h0);
      check("t4:busy", busy, 0);
      check("t4:wr_en", wr_en, 0);
      run_load(16'h00AA, 0);
      check("t4:lut_ready", lut_ready, 1);

      for (int i = 0; i < 3; i++) step(1, 16'h5555, 0, 0, 16'h0);
      check("t5:overrun", overrun, 1);
      check("t5:lut_ready", lut_ready, 1);
      step(0, 16'h0, 1, 0, 16'h0);
      check("t5:overrun_clr", overrun, 0);
      check("t5:checksum_clr", checksum, 0);

      step(1, 16'h0101, 0, 0, 16'h0);
      step(1, 16'h0202, 0, 0, 16'h0);
      s_valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("t6:s_ready", s_ready, 0);
      check_regs("t6");
      @(posedge clk);
      #1;
      check("t6:wr_en_held", wr_en, 0);
      s_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_regs("t6post");

      for (int i = 0; i < 1500; i++) begin
         bit          v, st, ab;
         logic [15:0] d, ex;
         v  = ($urandom % 4) != 0;
         d  = 16'($urandom);
         st = ($urandom % 12) == 0;
         ab = ($urandom % 40) == 0;
         ex = ($urandom % 2) ? 16'((m_sum + d) % 65536) : 16'($urandom);
         step(v, d, st, ab, ex);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
